maze_playfield: RTL and testbench
=================================

# maze_playfield

Tile-based playfield generator for the tank display. Holds a ROWS×COLS wall bitmap, prefetches one tile row per scanline during horizontal blank, and drives the per-pixel `playfield` bit. That bit feeds the tank controllers' collision input and the video mixer. A request/acknowledge write port lets game logic set or clear individual wall tiles (destructible walls) without tearing the visible frame.

## Interface
Parameters:
- TILE_SHIFT, 4: log2 of tile size in pixels (16×16 tiles).
- COLS, 40: tiles per row.
- ROWS, 30: tile rows.
- H_VISIBLE, 640: visible pixels per line.
- V_VISIBLE, 480: visible lines.
- V_TOTAL, 525: total lines per frame.

Ports:
- clk  in  1  pixel clock (same as hvsync generator).
- reset  in  1  reset, asynchronous, active-high; clock clk.
- hpos  in  10  current pixel column from hvsync generator.
- vpos  in  10  current line from hvsync generator.
- playfield  out  1  wall bit for the pixel at the previous cycle's hpos/vpos.
- ready  out  1  high once the init sweep is done.
- wr_req  in  1  write request, level; held until wr_ack.
- wr_row  in  5  target tile row.
- wr_col  in  6  target tile column.
- wr_val  in  1  new wall value (1 = wall).
- wr_ack  out  1  one-cycle pulse; request consumed.

## Operation
- Storage: `maze[0:ROWS-1]`, each COLS bits, single-port. At most one access per cycle: a row read or a row read-modify-write.
- Line buffer `line_buf` (COLS bits) holds the tile row for the line being drawn.
- FSM states:
  - INIT: row counter `ir` runs 0..ROWS-1 and clears one row per cycle. Moves to IDLE after row ROWS-1. ready=0. wr_req is ignored and not acked. playfield=0.
  - IDLE: ready=1. Accepts fetch and write events.
  - WRITE: single cycle. Commits the pending write, then returns to IDLE.
- Line fetch at hpos == H_VISIBLE in IDLE:
  - nv = (vpos == V_TOTAL-1) ? 0 : vpos+1.
  - If nv < V_VISIBLE, load `line_buf <= maze[nv >> TILE_SHIFT]`. Otherwise leave line_buf unchanged.
- Write acceptance, in IDLE when wr_req=1 and no fetch this cycle:
  - Latch row, col and value, then go to WRITE.
  - In WRITE, set `maze[row][col] <= val` and pulse wr_ack in the same cycle.
  - A fetch that coincides with WRITE is delayed one cycle. The fetch takes priority over new requests.
  - The fetch decision uses the vpos value latched at hpos == H_VISIBLE.
- Out-of-range write (row ≥ ROWS or col ≥ COLS): acked, maze unchanged.
- Writes never modify line_buf. A change becomes visible at the next fetch of that row, so there is no mid-line tearing.
- Pixel output, registered every cycle:
  - `playfield <= (hpos < H_VISIBLE && vpos < V_VISIBLE) ? line_buf[hpos >> TILE_SHIFT] : 0`.
  - Forced to 0 when ready=0.
  - Column index is always < COLS when hpos < H_VISIBLE (COLS·2^TILE_SHIFT == H_VISIBLE).
- Reset mid-operation: any pending write is dropped, with no ack. INIT restarts from row 0.

## Timing
- Reset values: playfield=0, ready=0, wr_ack=0, line_buf=0, state=INIT, ir=0.
- INIT lasts exactly ROWS cycles after reset release. ready rises on cycle ROWS.
- Pixel latency: 1 clk from hpos/vpos to playfield.
- Write latency:
  - Request seen in IDLE at cycle t: wr_ack is high at t+1 and the maze is updated at the t+1 edge.
  - If t is a fetch cycle: ack at t+2.
- Back-to-back: the requester must drop or change wr_req in the cycle after wr_ack. A still-high wr_req at t+2 is a new request. Maximum rate is one write per 2 cycles.
- Fetch occurs during hblank. line_buf is stable for the whole next visible line.

## Configuration
- MAZE_BORDER_EN defined:
  - Tiles with col 0, col COLS-1, row 0 or row ROWS-1 always read as wall. They are ORed into the fetched row, with full-row ones on rows 0 and ROWS-1.
  - Writes targeting border tiles are acked but leave the maze unchanged.
- MAZE_BORDER_EN undefined: playfield reflects memory contents only. All in-range tiles are writable.

## Test plan
- Reset, then run: ready=0 for 30 cycles, then 1. playfield=0 over the whole first frame (undefined macro).
- Write (row 2, col 5, val 1) in IDLE: wr_ack one cycle later. Next frame: playfield=1 for hpos 80..95 on lines 32..47 (observed one cycle late), 0 elsewhere.
- Write with wr_req asserted exactly at hpos=640 on vpos=40: wr_ack delayed to cycle +2. Line 41 still uses the old row 2 data. Change appears from the next fetch of row 2 onward.
- Write (row 30, col 3) and (row 0, col 40): both acked, no playfield change anywhere.
- With MAZE_BORDER_EN: after init, playfield=1 for all of lines 0..15 and 464..479 and for hpos 0..15 and 624..639. A write (0,0,val 0) is acked and the border remains.
- Assert reset while in WRITE: no wr_ack, target tile unchanged. INIT re-runs and ready falls to 0 for 30 cycles.

Source files
------------

// File: rtl/maze_playfield.sv
// ---------------------------------------------------------------------------
// maze_playfield - ROWSxCOLS wall bitmap, hblank row prefetch, req/ack tile writes
// Optional: MAZE_BORDER_EN forces the outer ring of tiles to read as wall.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module maze_playfield #(
  parameter int TILE_SHIFT = 4,
  parameter int COLS       = 40,
  parameter int ROWS       = 30,
  parameter int H_VISIBLE  = 640,
  parameter int V_VISIBLE  = 480,
  parameter int V_TOTAL    = 525
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  output logic       playfield,
  output logic       ready,
  input  logic       wr_req,
  input  logic [4:0] wr_row,
  input  logic [5:0] wr_col,
  input  logic       wr_val,
  output logic       wr_ack
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ROW_W-1:0] ir_q, ir_d;
  logic [COLS-1:0]  line_buf_q;
  logic             playfield_q;
  logic             fetch_pend_q;
  logic [9:0]       vlat_q;
  logic [4:0]       wrow_q;
  logic [5:0]       wcol_q;
  logic             wval_q;
  logic [COLS-1:0]  maze_q [ROWS];

  logic [9:0]       w_fetch_v;
  logic [9:0]       w_nv;
  logic [ROW_W-1:0] w_frow;
  logic             w_fetch;
  logic             w_load;
  logic             w_accept;
  logic             w_wr_ok;
  logic [COLS-1:0]  w_row_rd;
  logic [COL_W-1:0] w_col;
  logic             w_pix;

  // A fetch that landed on a WRITE cycle replays next cycle with the vpos captured then.
  always_comb begin
    w_fetch   = (state_q == S_IDLE) && ((hpos == 10'(H_VISIBLE)) || fetch_pend_q);
    w_fetch_v = fetch_pend_q ? vlat_q : vpos;
    w_nv      = (w_fetch_v == 10'(V_TOTAL - 1)) ? 10'd0 : w_fetch_v + 10'd1;
    w_frow    = w_nv[TILE_SHIFT +: ROW_W];
    w_load    = w_fetch && (w_nv < 10'(V_VISIBLE));
    w_accept  = (state_q == S_IDLE) && wr_req && !w_fetch;
  end

  always_comb begin
    w_row_rd = maze_q[w_frow];
`ifdef MAZE_BORDER_EN
    if (w_frow == '0 || int'(w_frow) == ROWS - 1) begin
      w_row_rd = '1;
    end else begin
      w_row_rd[0]      = 1'b1;
      w_row_rd[COLS-1] = 1'b1;
    end
`endif
  end

  always_comb begin
    w_wr_ok = (int'(wrow_q) < ROWS) && (int'(wcol_q) < COLS);
`ifdef MAZE_BORDER_EN
    if (wrow_q == '0 || int'(wrow_q) == ROWS - 1 || wcol_q == '0 || int'(wcol_q) == COLS - 1) begin
      w_wr_ok = 1'b0;
    end
`endif
  end

  always_comb begin
    w_col = hpos[TILE_SHIFT +: COL_W];
    w_pix = ready && (hpos < 10'(H_VISIBLE)) && (vpos < 10'(V_VISIBLE)) && line_buf_q[w_col];
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_INIT: begin
        ir_d = ir_q + ROW_W'(1);
        if (int'(ir_q) == ROWS - 1) begin
          state_d = S_IDLE;
          ir_d    = '0;
        end
      end
      S_IDLE: begin
        if (w_accept) state_d = S_WRITE;
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ready     = (state_q != S_INIT);
    wr_ack    = (state_q == S_WRITE);
    playfield = playfield_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_buf_q   <= '0;
      playfield_q  <= 1'b0;
      fetch_pend_q <= 1'b0;
      vlat_q       <= '0;
      wrow_q       <= '0;
      wcol_q       <= '0;
      wval_q       <= 1'b0;
    end else begin
      if (w_load) line_buf_q <= w_row_rd;
      if (state_q == S_WRITE && hpos == 10'(H_VISIBLE)) begin
        fetch_pend_q <= 1'b1;
        vlat_q       <= vpos;
      end else if (w_fetch) begin
        fetch_pend_q <= 1'b0;
      end
      if (w_accept) begin
        wrow_q <= wr_row;
        wcol_q <= wr_col;
        wval_q <= wr_val;
      end
      playfield_q <= w_pix;
    end
  end

  // Storage is cleared by the INIT sweep rather than by reset.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      maze_q[ir_q] <= '0;
    end else if (state_q == S_WRITE && w_wr_ok) begin
      maze_q[wrow_q][wcol_q] <= wval_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_maze_playfield.sv
// tb_maze_playfield - scoreboard bench for maze_playfield (pixel queue + write handshakes).
`timescale 1ns/1ps
`default_nettype none

module tb_maze_playfield;

  localparam int ROWS = 30;
  localparam int COLS = 40;
  localparam int HV   = 640;
  localparam int VV   = 480;
  localparam int VT   = 525;
  localparam int TS   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] hpos = '0;
  logic [9:0] vpos = '0;
  logic       wr_req = 1'b0;
  logic [4:0] wr_row = '0;
  logic [5:0] wr_col = '0;
  logic       wr_val = 1'b0;
  logic       playfield;
  logic       ready;
  logic       wr_ack;

  maze_playfield dut (
    .clk      (clk),
    .reset    (reset),
    .hpos     (hpos),
    .vpos     (vpos),
    .playfield(playfield),
    .ready    (ready),
    .wr_req   (wr_req),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_val   (wr_val),
    .wr_ack   (wr_ack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  bit maze_m [ROWS][COLS];
  bit lbuf_m [COLS];
  bit ready_m = 1'b0;
  int init_m  = 0;
  bit exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (hpos=%0d vpos=%0d t=%0t)", tag, obs, exp, hpos, vpos, $time);
    end
  endtask

  task automatic model_reset();
    ready_m = 1'b0;
    init_m  = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) maze_m[r][c] = 1'b0;
    for (int c = 0; c < COLS; c++) lbuf_m[c] = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_fetch(input int v);
    int nv;
    int r;
    nv = (v == VT - 1) ? 0 : v + 1;
    if (nv < VV) begin
      r = nv >> TS;
      for (int c = 0; c < COLS; c++) begin
        lbuf_m[c] = maze_m[r][c];
`ifdef MAZE_BORDER_EN
        if (r == 0 || r == ROWS - 1 || c == 0 || c == COLS - 1) lbuf_m[c] = 1'b1;
`endif
      end
    end
  endtask

  // One clock: push the expected pixel, clock, advance the model, pop and compare.
  task automatic tick();
    bit e;
    e = (!reset && ready_m && hpos < HV && vpos < VV) ? lbuf_m[hpos >> TS] : 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (!reset) begin
      if (ready_m && hpos == HV) model_fetch(int'(vpos));
      if (!ready_m) begin
        init_m++;
        if (init_m == ROWS) ready_m = 1'b1;
      end
    end
    chk("playfield", playfield, exp_q.pop_front());
  endtask

  task automatic scan_line(input int v);
    vpos = 10'(v);
    for (int h = 0; h <= HV; h++) begin
      hpos = 10'(h);
      tick();
    end
  endtask

  task automatic show(input int v);
    hpos = 10'(HV);
    vpos = (v == 0) ? 10'(VT - 1) : 10'(v - 1);
    tick();
    scan_line(v);
  endtask

  task automatic model_write(input int r, input int c, input bit val);
    bit ok;
    ok = (r < ROWS) && (c < COLS);
`ifdef MAZE_BORDER_EN
    if (r == 0 || r == ROWS - 1 || c == 0 || c == COLS - 1) ok = 1'b0;
`endif
    if (ok) maze_m[r][c] = val;
  endtask

  task automatic do_write(input int r, input int c, input bit val);
    hpos   = 10'd700;
    vpos   = 10'd100;
    wr_row = 5'(r);
    wr_col = 6'(c);
    wr_val = val;
    wr_req = 1'b1;
    chk("wr_ack_pre", wr_ack, 0);
    tick();
    chk("wr_ack_t1", wr_ack, 1);
    wr_req = 1'b0;
    model_write(r, c, val);
    tick();
    chk("wr_ack_drop", wr_ack, 0);
  endtask

  task automatic run_init();
    for (int i = 1; i <= ROWS; i++) begin
      tick();
      chk("ready_init", ready, (i == ROWS) ? 1 : 0);
      chk("wr_ack_init", wr_ack, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    hpos = 10'd100;
    vpos = 10'd5;
    repeat (3) tick();
    chk("rst_ready", ready, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_playfield", playfield, 0);

    // Requests during INIT must be ignored.
    wr_row = 5'd1;
    wr_col = 6'd1;
    wr_val = 1'b1;
    wr_req = 1'b1;
    reset  = 1'b0;
    run_init();
    wr_req = 1'b0;

    // First frame: empty maze, including a vblank line.
    show(0);
    show(240);
    vpos = 10'd500;
    for (int h = 0; h < 20; h++) begin
      hpos = 10'(h);
      tick();
    end

    // Single tile write, visible on lines 32..47 at hpos 80..95.
    do_write(2, 5, 1);
    show(31);
    scan_line(32);
    show(47);
    scan_line(48);

    // Request raised on a fetch cycle: ack at +2, line 41 keeps the old row.
    wr_row = 5'd2;
    wr_col = 6'd6;
    wr_val = 1'b1;
    hpos   = 10'(HV);
    vpos   = 10'd40;
    wr_req = 1'b1;
    tick();
    chk("ack_fetch_t1", wr_ack, 0);
    hpos = 10'(HV + 1);
    tick();
    chk("ack_fetch_t2", wr_ack, 1);
    wr_req = 1'b0;
    model_write(2, 6, 1);
    hpos = 10'(HV + 2);
    tick();
    chk("ack_fetch_t3", wr_ack, 0);
    scan_line(41);
    scan_line(42);

    // WRITE lands on hpos==640: fetch replays next cycle with the captured vpos.
    wr_row = 5'd2;
    wr_col = 6'd7;
    wr_val = 1'b1;
    hpos   = 10'(HV - 1);
    vpos   = 10'd42;
    wr_req = 1'b1;
    tick();
    chk("ack_defer_t1", wr_ack, 1);
    wr_req = 1'b0;
    model_write(2, 7, 1);
    hpos = 10'(HV);
    tick();
    chk("ack_defer_t2", wr_ack, 0);
    hpos = 10'(HV + 1);
    vpos = 10'd99;
    tick();
    scan_line(43);

    // Out-of-range writes: acked, nothing changes (rows 0 and 14 cover index aliasing).
    do_write(30, 3, 1);
    do_write(0, 40, 1);
    show(0);
    show(224);

`ifdef MAZE_BORDER_EN
    do_write(0, 0, 0);
    show(0);
    show(479);
`endif

    // Reset during WRITE: no ack, INIT re-runs.
    hpos   = 10'd700;
    vpos   = 10'd100;
    wr_row = 5'd3;
    wr_col = 6'd7;
    wr_val = 1'b1;
    wr_req = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    chk("ack_reset", wr_ack, 0);
    chk("ready_reset", ready, 0);
    model_reset();
    wr_req = 1'b0;
    tick();
    reset = 1'b0;
    run_init();
    show(48);
    show(32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
